opb_register_bank_ppc2simulink: RTL and testbench

OPB_REGISTER_BANK_PPC2SIMULINK -- requirements
Module: opb_register_bank_ppc2simulink

---
 rtl/opb_register_bank_ppc2simulink.sv | 133 +++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing a small bank of 32-bit user registers to fabric logic.
// Single-beat transfers with one-cycle ack latency; selected registers can be self-clearing.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01008100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010081FF,
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [15:0] C_PULSE_MASK = 16'h0000,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:3]                  OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]    user_data_out,
  output logic [C_NUM_REGS-1:0]       user_wr_strobe
);

  // state  | meaning
  // IDLE   | waiting for a select that hits the decode window
  // ACK    | xferAck or errAck is high for this single cycle
  // WAIT   | transfer done, waiting for select to drop before re-arming
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [C_OPB_AWIDTH-1:0] BASE = C_OPB_AWIDTH'(C_BASEADDR);
  localparam logic [C_OPB_AWIDTH-1:0] HIGH = C_OPB_AWIDTH'(C_HIGHADDR);

  logic [1:0]              state;
  logic [31:0]             regs [C_NUM_REGS];
  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic [C_OPB_AWIDTH-1:0] word_idx;
  logic                    hit;
  logic                    idx_ok;
  logic                    accept;
  logic [3:0]              be_v;
  logic [31:0]             wr_data;
  logic [31:0]             rd_sel;
  logic [31:0]             rd_data;
  logic [C_NUM_REGS-1:0]   wr_sel;
  logic                    unused_ok;

  // Bus bit 0 is the MSB, so the numeric values carry over unchanged;
  // be_v[3] therefore qualifies the most significant byte.
  assign addr     = OPB_ABus;
  assign be_v     = OPB_BE;
  assign wr_data  = OPB_DBus;
  assign offset   = addr - BASE;
  assign word_idx = offset >> 2;
  assign hit      = OPB_select && (addr >= BASE) && (addr <= HIGH);
  assign idx_ok   = word_idx < C_OPB_AWIDTH'(C_NUM_REGS);
  assign accept   = (state == S_IDLE) && hit;

  assign unused_ok = ^{OPB_seqAddr, ($bits(C_FAMILY) > 0)};

  always_comb begin
    rd_sel = '0;
    wr_sel = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (word_idx == C_OPB_AWIDTH'(i)) begin
        rd_sel    = regs[i];
        wr_sel[i] = accept && idx_ok && !OPB_RNW;
      end
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (hit) state <= S_ACK;
        S_ACK:   state <= S_WAIT;
        S_WAIT:  if (!OPB_select) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pulse registers clear the cycle after the write strobe, so the written
  // value is visible for exactly the strobe cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= C_RESET_VAL;
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (be_v[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end else if (C_PULSE_MASK[i] && user_wr_strobe[i]) begin
          regs[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      Sl_xferAck     <= 1'b0;
      Sl_errAck      <= 1'b0;
      rd_data        <= '0;
      user_wr_strobe <= '0;
    end else begin
      Sl_xferAck     <= accept && idx_ok;
      Sl_errAck      <= accept && !idx_ok;
      rd_data        <= (accept && idx_ok && OPB_RNW) ? rd_sel : '0;
      user_wr_strobe <= wr_sel;
    end
  end

  assign Sl_DBus    = rd_data;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: register 0 is built as a pulse register,
// expected acks and read data flow through a scoreboard queue.
module tb_opb_register_bank_ppc2simulink;
  localparam logic [31:0] BASE  = 32'h01008100;
  localparam logic [31:0] HIGH  = 32'h010081FF;
  localparam int          NREGS = 4;
  localparam logic [31:0] RVAL  = 32'h00000000;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [0:31]           abus;
  logic [0:31]           dbus;
  logic [0:3]            be;
  logic                  rnw;
  logic                  select;
  logic                  seq_addr;
  logic [0:31]           sl_dbus;
  logic                  xfer_ack;
  logic                  err_ack;
  logic                  retry;
  logic                  tout_sup;
  logic [NREGS*32-1:0]   user_data;
  logic [NREGS-1:0]      wr_strobe;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_NUM_REGS   (NREGS),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_PULSE_MASK (16'h0001),
    .C_RESET_VAL  (RVAL),
    .C_FAMILY     ("virtex6")
  ) dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst_n),
    .OPB_ABus       (abus),
    .OPB_BE         (be),
    .OPB_DBus       (dbus),
    .OPB_RNW        (rnw),
    .OPB_select     (select),
    .OPB_seqAddr    (seq_addr),
    .Sl_DBus        (sl_dbus),
    .Sl_xferAck     (xfer_ack),
    .Sl_errAck      (err_ack),
    .Sl_retry       (retry),
    .Sl_toutSup     (tout_sup),
    .user_data_out  (user_data),
    .user_wr_strobe (wr_strobe)
  );

  typedef struct {
    logic        xfer;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [NREGS];
  int          checks = 0;
  int          errors = 0;

  // observations of the most recent transfer
  logic                o_xfer, o_err, o_ack_next;
  logic [31:0]         o_rd, o_rd_next;
  logic [NREGS-1:0]    o_ws, o_ws_next;
  logic [NREGS*32-1:0] o_ud, o_ud_next;
  int                  o_lat;

  function automatic logic [NREGS*32-1:0] model_vec();
    logic [NREGS*32-1:0] v;
    for (int i = 0; i < NREGS; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  task automatic bus_xfer(input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic r);
    @(negedge clk);
    abus = a; be = b; dbus = d; rnw = r; select = 1'b1;
    o_xfer = 1'b0; o_err = 1'b0; o_rd = '0; o_lat = 0; o_ws = '0; o_ud = user_data;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (xfer_ack || err_ack) begin
        o_xfer = xfer_ack; o_err = err_ack; o_rd = sl_dbus;
        o_ws = wr_strobe; o_ud = user_data; o_lat = c;
        break;
      end
    end
    select = 1'b0; rnw = 1'b1; be = '0; dbus = '0;
    @(negedge clk);
    o_ack_next = xfer_ack | err_ack;
    o_rd_next  = sl_dbus;
    o_ws_next  = wr_strobe;
    o_ud_next  = user_data;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({xfer_ack, err_ack, retry, tout_sup} !== 4'b0000 || sl_dbus !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus_outputs: got ack=%b err=%b retry=%b tout=%b dbus=%h, want all 0",
               xfer_ack, err_ack, retry, tout_sup, sl_dbus);
    end
    checks++;
    if (user_data !== {NREGS{RVAL}} || wr_strobe !== '0) begin
      errors++;
      $display("FAIL reset_user_outputs: got data=%h strobe=%b, want data=%h strobe=0",
               user_data, wr_strobe, {NREGS{RVAL}});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (xfer_ack !== 1'b0 || user_data !== {NREGS{RVAL}}) begin
      errors++;
      $display("FAIL reset_release_idle: got ack=%b data=%h, want ack=0 data=%h",
               xfer_ack, user_data, {NREGS{RVAL}});
    end
  endtask

  task automatic test_write_full();
    exp_t e;
    sb.push_back('{1'b1, 1'b0, 32'h0});
    model[1] = 32'hDEADBEEF;
    bus_xfer(BASE + 32'h4, 4'b1111, 32'hDEADBEEF, 1'b0);
    e = sb.pop_front();
    checks++;
    if (o_xfer !== e.xfer || o_err !== e.err || o_lat !== 1) begin
      errors++;
      $display("FAIL write_full_ack: got xfer=%b err=%b latency=%0d, want xfer=%b err=%b latency=1",
               o_xfer, o_err, o_lat, e.xfer, e.err);
    end
    checks++;
    if (o_ud[63:32] !== 32'hDEADBEEF || o_ws !== 4'b0010) begin
      errors++;
      $display("FAIL write_full_data: got reg1=%h strobe=%b, want reg1=deadbeef strobe=0010",
               o_ud[63:32], o_ws);
    end
    checks++;
    if (o_ack_next !== 1'b0 || o_ws_next !== 4'b0000 || o_ud_next !== model_vec()) begin
      errors++;
      $display("FAIL write_full_after: got ack=%b strobe=%b data=%h, want ack=0 strobe=0000 data=%h",
               o_ack_next, o_ws_next, o_ud_next, model_vec());
    end
  endtask

  task automatic test_byte_enables();
    exp_t e;
    sb.push_back('{1'b1, 1'b0, 32'h0});
    model[2] = 32'h11223344;
    bus_xfer(BASE + 32'h8, 4'b1111, 32'h11223344, 1'b0);
    e = sb.pop_front();
    sb.push_back('{1'b1, 1'b0, 32'h0});
    model[2] = 32'h11BB33DD;
    bus_xfer(BASE + 32'h8, 4'b0101, 32'hAABBCCDD, 1'b0);
    e = sb.pop_front();
    checks++;
    if (o_xfer !== e.xfer || o_ud[95:64] !== model[2] || o_ws !== 4'b0100) begin
      errors++;
      $display("FAIL byte_enable_write: got xfer=%b reg2=%h strobe=%b, want xfer=1 reg2=%h strobe=0100",
               o_xfer, o_ud[95:64], o_ws, model[2]);
    end
    sb.push_back('{1'b1, 1'b0, model[2]});
    bus_xfer(BASE + 32'h8, 4'b1111, 32'h0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (o_xfer !== e.xfer || o_rd !== e.rdata || o_rd_next !== 32'h0) begin
      errors++;
      $display("FAIL byte_enable_read: got xfer=%b rd=%h rd_next=%h, want xfer=1 rd=%h rd_next=0",
               o_xfer, o_rd, o_rd_next, e.rdata);
    end
  endtask

  task automatic test_be_zero();
    exp_t e;
    sb.push_back('{1'b1, 1'b0, 32'h0});
    bus_xfer(BASE + 32'hC, 4'b0000, 32'h55AA55AA, 1'b0);
    e = sb.pop_front();
    checks++;
    if (o_xfer !== e.xfer || o_ws !== 4'b1000 || o_ud !== model_vec()) begin
      errors++;
      $display("FAIL be_zero_write: got xfer=%b strobe=%b data=%h, want xfer=1 strobe=1000 data=%h",
               o_xfer, o_ws, o_ud, model_vec());
    end
  endtask

  task automatic test_pulse();
    exp_t e;
    sb.push_back('{1'b1, 1'b0, 32'h0});
    bus_xfer(BASE, 4'b1111, 32'h00000001, 1'b0);
    e = sb.pop_front();
    checks++;
    if (o_xfer !== e.xfer || o_ud[31:0] !== 32'h1 || o_ud_next[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL pulse_reg: got xfer=%b reg0=%h reg0_next=%h, want xfer=1 reg0=1 reg0_next=0",
               o_xfer, o_ud[31:0], o_ud_next[31:0]);
    end
    sb.push_back('{1'b1, 1'b0, 32'h0});
    bus_xfer(BASE, 4'b1111, 32'h0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (o_xfer !== e.xfer || o_rd !== e.rdata) begin
      errors++;
      $display("FAIL pulse_read: got xfer=%b rd=%h, want xfer=1 rd=%h", o_xfer, o_rd, e.rdata);
    end
  endtask

  task automatic test_error();
    exp_t e;
    sb.push_back('{1'b0, 1'b1, 32'h0});
    bus_xfer(BASE + 32'h10, 4'b1111, 32'hFFFFFFFF, 1'b0);
    e = sb.pop_front();
    checks++;
    if (o_xfer !== e.xfer || o_err !== e.err || o_lat !== 1 || o_ack_next !== 1'b0) begin
      errors++;
      $display("FAIL error_write_ack: got xfer=%b err=%b latency=%0d next=%b, want xfer=0 err=1 latency=1 next=0",
               o_xfer, o_err, o_lat, o_ack_next);
    end
    checks++;
    if (o_ws !== 4'b0000 || o_ud_next !== model_vec()) begin
      errors++;
      $display("FAIL error_write_regs: got strobe=%b data=%h, want strobe=0000 data=%h",
               o_ws, o_ud_next, model_vec());
    end
    sb.push_back('{1'b0, 1'b1, 32'h0});
    bus_xfer(HIGH - 32'h3, 4'b1111, 32'h0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (o_xfer !== e.xfer || o_err !== e.err || o_rd !== e.rdata) begin
      errors++;
      $display("FAIL error_read_top: got xfer=%b err=%b rd=%h, want xfer=0 err=1 rd=0",
               o_xfer, o_err, o_rd);
    end
  endtask

  task automatic test_window();
    logic [31:0] addrs [3];
    addrs[0] = BASE - 32'h4;
    addrs[1] = HIGH + 32'h1;
    addrs[2] = 32'h00000000;
    for (int k = 0; k < 3; k++) begin
      bus_xfer(addrs[k], 4'b1111, 32'h12345678, 1'b0);
      checks++;
      if (o_lat !== 0 || o_ud_next !== model_vec()) begin
        errors++;
        $display("FAIL out_of_window_%0d: got latency=%0d data=%h, want no ack data=%h",
                 k, o_lat, o_ud_next, model_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] a [4];
    logic [31:0] d [4];
    logic        r [4];
    a[0] = BASE + 32'h4; d[0] = 32'h0BADF00D; r[0] = 1'b0;
    a[1] = BASE + 32'hC; d[1] = 32'h76543210; r[1] = 1'b0;
    a[2] = BASE + 32'h4; d[2] = 32'h0;        r[2] = 1'b1;
    a[3] = BASE + 32'hC; d[3] = 32'h0;        r[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (!r[k]) model[(a[k] - BASE) >> 2] = d[k];
      sb.push_back('{1'b1, 1'b0, r[k] ? model[(a[k] - BASE) >> 2] : 32'h0});
      bus_xfer(a[k], 4'b1111, d[k], r[k]);
      e = sb.pop_front();
      checks++;
      if (o_xfer !== e.xfer || o_err !== e.err || o_rd !== e.rdata || o_ud_next !== model_vec()) begin
        errors++;
        $display("FAIL back_to_back_%0d: got xfer=%b err=%b rd=%h data=%h, want xfer=1 err=0 rd=%h data=%h",
                 k, o_xfer, o_err, o_rd, o_ud_next, e.rdata, model_vec());
      end
    end
  endtask

  task automatic test_held_select();
    int acks;
    logic [31:0] rd;
    acks = 0;
    rd = '0;
    @(negedge clk);
    abus = BASE + 32'h4; be = 4'b1111; rnw = 1'b1; select = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (xfer_ack) acks++;
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL held_select_single: got %0d acks, want 1", acks);
    end
    select = 1'b0;
    @(negedge clk);
    if (xfer_ack) acks++;
    select = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (xfer_ack) begin
        acks++;
        rd = sl_dbus;
      end
    end
    checks++;
    if (acks !== 2 || rd !== model[1]) begin
      errors++;
      $display("FAIL held_select_rearm: got %0d acks rd=%h, want 2 acks rd=%h", acks, rd, model[1]);
    end
    select = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_ack();
    exp_t e;
    @(negedge clk);
    abus = BASE + 32'h4; be = 4'b1111; dbus = 32'hCAFEF00D; rnw = 1'b0; select = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NREGS; i++) model[i] = RVAL;
    checks++;
    if (xfer_ack !== 1'b0 || err_ack !== 1'b0 || sl_dbus !== 32'h0 ||
        wr_strobe !== '0 || user_data !== model_vec()) begin
      errors++;
      $display("FAIL reset_mid_ack: got ack=%b err=%b dbus=%h strobe=%b data=%h, want all 0 data=%h",
               xfer_ack, err_ack, sl_dbus, wr_strobe, user_data, model_vec());
    end
    @(negedge clk);
    select = 1'b0; rnw = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{1'b1, 1'b0, RVAL});
    bus_xfer(BASE + 32'h4, 4'b1111, 32'h0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (o_xfer !== e.xfer || o_rd !== e.rdata || o_lat !== 1) begin
      errors++;
      $display("FAIL after_reset_read: got xfer=%b rd=%h latency=%0d, want xfer=1 rd=%h latency=1",
               o_xfer, o_rd, o_lat, e.rdata);
    end
  endtask

  initial begin
    abus = '0; dbus = '0; be = '0; rnw = 1'b1; select = 1'b0; seq_addr = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = RVAL;
    test_reset();
    test_write_full();
    test_byte_enables();
    test_be_zero();
    test_pulse();
    test_error();
    test_window();
    test_back_to_back();
    test_held_select();
    test_reset_mid_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
